// File: rtl/f1_reaction_timer.sv
// ============================================================================
// f1_reaction_timer : measures tick-count reaction time from lights-out to
// button press on an F1 start-light bar and flags jump starts.
// Rev 1.0
// ============================================================================
`default_nettype none

module f1_reaction_timer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] lights,
    input  logic             trigger,
    input  logic             tick,
    output logic [CNT_W-1:0] time_out,
    output logic             valid,
    output logic             jump_start,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMING = 3'd1,
        S_ALL_ON = 3'd2,
        S_TIMING = 3'd3,
        S_DONE   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [CNT_W-1:0]   time_out_q, time_out_d;
    logic               trigger_q;
    logic               valid_q, valid_d;
    logic               jump_q, jump_d;

    logic               w_press;
    logic               w_full;
    logic               w_zero;

    assign w_press = trigger & ~trigger_q;
    assign w_full  = (lights == {WIDTH{1'b1}});
    assign w_zero  = (lights == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            counter_q  <= '0;
            time_out_q <= '0;
            trigger_q  <= 1'b0;
            valid_q    <= 1'b0;
            jump_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            time_out_q <= time_out_d;
            trigger_q  <= trigger;
            valid_q    <= valid_d;
            jump_q     <= jump_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        time_out_d = time_out_q;
        case (state_q)
            S_IDLE: begin
                if (w_full)       state_d = S_ALL_ON;
                else if (!w_zero) state_d = S_ARMING;
            end
            S_ARMING: begin
                if (w_press)      state_d = S_FAULT;
                else if (w_full)  state_d = S_ALL_ON;
                else if (w_zero)  state_d = S_IDLE;
            end
            S_ALL_ON: begin
                // A press coinciding with lights-out is still a jump start.
                if (w_press) begin
                    state_d = S_FAULT;
                end else if (w_zero) begin
                    state_d   = S_TIMING;
                    counter_d = '0;
                end else if (!w_full) begin
                    state_d = S_ARMING;
                end
            end
            S_TIMING: begin
                if (w_press) begin
                    state_d    = S_DONE;
                    time_out_d = counter_q;
                end else if (!w_zero) begin
                    state_d = S_ARMING;
                end else if (tick && (counter_q != {CNT_W{1'b1}})) begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                if (w_zero && !trigger) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered flags decoded from the next state so they align with it.
    assign valid_d = (state_d == S_DONE);
    assign jump_d  = (state_d == S_FAULT);

    assign time_out   = time_out_q;
    assign valid      = valid_q;
    assign jump_start = jump_q;
    assign busy       = (state_q == S_ARMING) || (state_q == S_ALL_ON) ||
                        (state_q == S_TIMING);

endmodule

`default_nettype wire

// File: tb/tb_f1_reaction_timer.sv
// ============================================================================
// tb_f1_reaction_timer : directed scoreboard bench for f1_reaction_timer.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_f1_reaction_timer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  lights;
    logic        trigger;
    logic        tick;
    logic [15:0] time_out;
    logic        valid;
    logic        jump_start;
    logic        busy;
    logic [3:0]  time_out4;
    logic        valid4;
    logic        jump_start4;
    logic        busy4;

    int          n_tests;
    int          n_fails;
    int          n_valid;
    int          sb[$];

    f1_reaction_timer #(.WIDTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lights     (lights),
        .trigger    (trigger),
        .tick       (tick),
        .time_out   (time_out),
        .valid      (valid),
        .jump_start (jump_start),
        .busy       (busy)
    );

    f1_reaction_timer #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .lights     (lights),
        .trigger    (trigger),
        .tick       (tick),
        .time_out   (time_out4),
        .valid      (valid4),
        .jump_start (jump_start4),
        .busy       (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: each valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            n_valid++;
            chk("sb_pending", int'(sb.size() > 0), 1);
            if (sb.size() > 0) chk("sb_time_out", int'(time_out), sb.pop_front());
        end
    end

    task automatic normal_round();
        logic [7:0] seq [8];
        seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        tick = 1'b1;
        for (int i = 0; i < 8; i++) begin
            lights = seq[i];
            step();
        end
        chk("round_busy_all_on", int'(busy), 1);
        lights = 8'h00;
        step();
        step(5);
        chk("round_busy_timing", int'(busy), 1);
        trigger = 1'b1;
        sb.push_back(5);
        step();
        chk("round_valid", int'(valid), 1);
        chk("round_time_out", int'(time_out), 5);
        chk("round_jump", int'(jump_start), 0);
        chk("round_busy_done", int'(busy), 0);
        trigger = 1'b0;
        step();
        chk("round_valid_once", int'(valid), 0);
        chk("round_time_out_held", int'(time_out), 5);
    endtask

    initial begin
        n_tests = 0;
        n_fails = 0;
        n_valid = 0;
        rst_n   = 1'b0;
        lights  = 8'h00;
        trigger = 1'b0;
        tick    = 1'b1;
        #3;
        chk("rst_time_out", int'(time_out), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_jump", int'(jump_start), 0);
        chk("rst_busy", int'(busy), 0);
        step(2);
        rst_n = 1'b1;
        step();

        // Normal round
        normal_round();

        // Jump start during the light sequence, trigger held through lights-out
        lights = 8'h01; step();
        lights = 8'h03; step();
        lights = 8'h07; trigger = 1'b1; step();
        chk("js_jump", int'(jump_start), 1);
        chk("js_valid", int'(valid), 0);
        chk("js_busy", int'(busy), 0);
        lights = 8'h00; step();
        chk("js_hold_fault", int'(jump_start), 1);
        trigger = 1'b0; step();
        chk("js_release", int'(jump_start), 0);
        chk("js_time_out_kept", int'(time_out), 5);

        // Press in the same cycle as lights-out
        lights = 8'hFF; step();
        chk("sim_all_on", int'(busy), 1);
        lights = 8'h00; trigger = 1'b1; step();
        chk("sim_jump", int'(jump_start), 1);
        chk("sim_valid", int'(valid), 0);
        trigger = 1'b0; step();
        chk("sim_exit", int'(jump_start), 0);

        // Tick gating: tick on every 4th TIMING cycle, press on the 21st
        lights = 8'hFF; step();
        lights = 8'h00; step();
        for (int i = 1; i <= 20; i++) begin
            tick = ((i - 1) % 4 == 0);
            step();
        end
        tick = 1'b0;
        trigger = 1'b1;
        sb.push_back(5);
        step();
        chk("gate_valid", int'(valid), 1);
        chk("gate_time_out", int'(time_out), 5);
        trigger = 1'b0; tick = 1'b1; step();

        // Saturation on the 4-bit instance, 30 ticks before the press
        lights = 8'hFF; step();
        lights = 8'h00; step();
        step(30);
        trigger = 1'b1;
        sb.push_back(30);
        step();
        chk("sat_valid4", int'(valid4), 1);
        chk("sat_time_out4", int'(time_out4), 15);
        chk("sat_time_out16", int'(time_out), 30);
        trigger = 1'b0; step();

        // Reset in the middle of TIMING
        lights = 8'hFF; step();
        lights = 8'h00; step();
        step(3);
        chk("mid_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_time_out", int'(time_out), 0);
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_jump", int'(jump_start), 0);
        chk("mid_rst_busy", int'(busy), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("mid_after_valid", int'(valid), 0);
        normal_round();

        step(2);
        chk("sb_empty", sb.size(), 0);
        chk("valid_pulses", n_valid, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/f1_reaction_timer.md
Name: f1_reaction_timer

Overview:
- Consumer end of the F1 start-light interface: watches the 8-bit light bar produced by the start-light FSM and the player's push button.
- Detects the "all lights on → lights out" event and measures the reaction time in tick units from lights-out to button press.
- Flags jump starts, i.e. a press before lights-out.
- Sits between the light-sequence FSM and the display/score logic.

Parameters:
- WIDTH, 8, width of the light bar; "all on" means all WIDTH bits set.
- CNT_W, 16, width of the reaction counter and result.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- lights  input  WIDTH  light bar from the start-light FSM; synchronous to clk.
- trigger  input  1  player button, already synchronised and debounced; level.
- tick  input  1  time-base enable; counter advances only in cycles where tick=1.
- time_out  output  CNT_W  last captured reaction time; held until the next capture.
- valid  output  1  one-cycle pulse when time_out is updated.
- jump_start  output  1  level; high while in FAULT.
- busy  output  1  high in ARMING, ALL_ON or TIMING.

Behaviour:
- Reset (async assert, sync-to-clk deassert):
  - state=IDLE; counter=0; trigger_q=0.
  - time_out=0; valid=0; jump_start=0; busy=0.
  - Reset mid-round discards everything; no valid pulse.
- Press detection: press = trigger & ~trigger_q; trigger_q registered every cycle in all states.
- FULL = (lights == all ones); ZERO = (lights == 0).
- States and transitions (evaluated every clk; first matching rule wins):
  - IDLE:
    - FULL → ALL_ON.
    - Else !ZERO → ARMING.
    - Presses ignored.
  - ARMING:
    - press → FAULT.
    - Else FULL → ALL_ON.
    - Else ZERO → IDLE (aborted sequence, no result).
  - ALL_ON:
    - press → FAULT. This includes a press in the same cycle lights go to 0.
    - Else ZERO → TIMING, with counter cleared to 0.
    - Else !FULL → ARMING.
  - TIMING:
    - press → DONE; time_out <= counter, using the value before any increment this cycle.
    - Else !ZERO → ARMING (new sequence started, no result).
    - Else if tick: counter <= counter+1, saturating at 2^CNT_W-1 (no wrap).
  - DONE:
    - Unconditional → IDLE next cycle.
    - valid=1 for exactly this one cycle (registered output, asserted the cycle after the press).
  - FAULT:
    - jump_start=1.
    - Exit to IDLE when ZERO and trigger=0 in the same cycle.
    - time_out unchanged; no valid.
- Latency:
  - press edge sampled in cycle N → valid and new time_out visible in cycle N+1.
  - Transition into FAULT → jump_start visible in cycle N+1.
- Reaction value: number of tick=1 cycles spent in TIMING strictly before the press cycle.
- Saturation: a saturated counter stays at all ones; the capture reports all ones; no other flag.
- lights values not of thermometer form are handled purely by the FULL/ZERO/else rules above.
- busy is decoded combinationally from state. valid and jump_start are registered.

Test Plan:
- Normal round: tick=1. Drive lights 01,03,07,0F,1F,3F,7F,FF (one per cycle), then 00. trigger rises on the 6th TIMING cycle → valid pulses once, time_out=5, jump_start stays 0, busy falls after DONE.
- Jump start: press while lights=07 → jump_start=1 the next cycle, no valid, time_out unchanged. Hold trigger high through lights=00 → stays FAULT. Release → IDLE, jump_start=0.
- Simultaneous: lights FF→00 in the same cycle as the trigger rising edge → FAULT and jump_start=1, no valid.
- Tick gating: tick=1 every 4th cycle starting at the first TIMING cycle. Press on the 21st TIMING cycle → time_out=5.
- Saturation with CNT_W=4, tick=1: no press for 30 TIMING cycles, then press → time_out=15 (0xF), valid=1.
- Reset mid-TIMING: after 3 ticks, pulse rst_n low → all outputs 0 immediately, state IDLE, no valid. A following normal round returns time_out=5 as in the first scenario.
